// File: rtl/free_list_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sys_defs (package)
// Purpose  : Core-wide sizing constants and the tag-carrying structs shared
//            by the free list, ROB and Map Table.
// Contents : NUM_PR, NUM_ARCH, NUM_ROB, NUM_SUPER, PRW,
//            PR_IDX_t, FL_ROB_OUT_t, ROB_FL_OUT_t
// Revision : 1.0 - initial release
// ============================================================================
package sys_defs;

  // Physical registers, architectural registers, ROB entries, machine width
  localparam int NUM_PR    = 64;
  localparam int NUM_ARCH  = 32;
  localparam int NUM_ROB   = 32;
  localparam int NUM_SUPER = 2;

  // Physical tag width
  localparam int PRW = $clog2(NUM_PR);

  typedef logic [PRW-1:0] PR_IDX_t;

  // Free list -> ROB / Map Table: fresh tags for one dispatch group
  typedef struct packed {
    PR_IDX_t [NUM_SUPER-1:0] T_idx;
  } FL_ROB_OUT_t;

  // ROB -> free list: previous mappings released at retirement
  typedef struct packed {
    PR_IDX_t [NUM_SUPER-1:0] Told_idx;
  } ROB_FL_OUT_t;

endpackage
`default_nettype wire

// File: rtl/fl_checkpoint_table.sv
`default_nettype none
// ============================================================================
// Module   : fl_checkpoint_table
// Purpose  : Per-ROB-entry snapshot of the free-list head pointer. Each
//            dispatched op records where the head will sit just after its
//            own tag was popped, so a mispredict at that op can restore the
//            head and release everything allocated younger than it.
// Ports    : clock            - rising-edge clock
//            reset            - asynchronous, active-low; clears all entries
//            wr_en[1:0]       - write strobe for each dispatch slot
//            wr_idx           - ROB index per slot, slot 0 in the low bits
//            wr_data          - head snapshot per slot, slot 0 in low bits
//            rd_idx           - ROB index of the mispredicted branch
//            rd_data          - snapshot stored at rd_idx (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module fl_checkpoint_table
  import sys_defs::*;
#(
  parameter int DEPTH  = NUM_ROB,
  parameter int IDX_W  = $clog2(NUM_ROB),
  parameter int DATA_W = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            wr_en,
  input  logic [2*IDX_W-1:0]    wr_idx,
  input  logic [2*DATA_W-1:0]   wr_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_W-1:0]     rd_data
);

  logic [DATA_W-1:0] r_ckpt [DEPTH];

  logic [IDX_W-1:0]  w_idx0;
  logic [IDX_W-1:0]  w_idx1;
  logic [DATA_W-1:0] w_data0;
  logic [DATA_W-1:0] w_data1;

  assign w_idx0  = wr_idx[IDX_W-1:0];
  assign w_idx1  = wr_idx[2*IDX_W-1:IDX_W];
  assign w_data0 = wr_data[DATA_W-1:0];
  assign w_data1 = wr_data[2*DATA_W-1:DATA_W];

  // The two slots of one dispatch group always target distinct ROB
  // entries; should they ever collide, slot 1 (the younger op) wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ckpt[i] <= '0;
      end
    end else begin
      if (wr_en[0]) begin
        r_ckpt[w_idx0] <= w_data0;
      end
      if (wr_en[1]) begin
        r_ckpt[w_idx1] <= w_data1;
      end
    end
  end

  // Read is combinational so the restored head lands in the same edge
  // that performs the rollback.
  assign rd_data = r_ckpt[rd_idx];

endmodule
`default_nettype wire

// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
// Module   : free_list
// Purpose  : Physical-register free list for the 2-wide R10000-style core.
//            Pops two fresh tags per dispatch group, pushes the two Told
//            tags released at retirement, and restores its head from a
//            per-ROB checkpoint on a branch mispredict so squashed tags
//            return to the pool in a single cycle.
// Ports    : clock            - rising-edge clock
//            reset            - asynchronous, active-low
//            en               - global state-update enable
//            dispatch_en      - pop two tags this cycle
//            ROB_idx          - ROB slots of the two dispatched ops
//            retire_en[1:0]   - retire slot valid ([1] only with [0])
//            Told_idx         - tags freed by the retiring ops
//            rollback_en      - mispredict recovery this cycle
//            ROB_rollback_idx - ROB index of the mispredicted branch
//            T_idx            - the two tags offered to dispatch (comb.)
//            FL_valid         - at least two tags are free
//            free_count       - number of free tags
// Options  : FL_DEBUG_EN - adds fl_debug / head_debug / tail_debug outputs
//            and immediate assertions on protocol violations. Functional
//            behaviour is identical with or without it.
// Revision : 1.0 - initial release
// ============================================================================
module free_list #(
  parameter int NUM_PR    = sys_defs::NUM_PR,
  parameter int NUM_ARCH  = sys_defs::NUM_ARCH,
  parameter int NUM_ROB   = sys_defs::NUM_ROB,
  parameter int NUM_SUPER = sys_defs::NUM_SUPER
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  en,
  input  logic                                  dispatch_en,
  input  logic [NUM_SUPER*$clog2(NUM_ROB)-1:0]  ROB_idx,
  input  logic [NUM_SUPER-1:0]                  retire_en,
  input  logic [NUM_SUPER*$clog2(NUM_PR)-1:0]   Told_idx,
  input  logic                                  rollback_en,
  input  logic [$clog2(NUM_ROB)-1:0]            ROB_rollback_idx,
  output logic [NUM_SUPER*$clog2(NUM_PR)-1:0]   T_idx,
  output logic                                  FL_valid,
  output logic [$clog2(NUM_PR-NUM_ARCH):0]      free_count
`ifdef FL_DEBUG_EN
  ,
  output logic [(NUM_PR-NUM_ARCH)*$clog2(NUM_PR)-1:0] fl_debug,
  output logic [$clog2(NUM_PR-NUM_ARCH):0]            head_debug,
  output logic [$clog2(NUM_PR-NUM_ARCH):0]            tail_debug
`endif
);

  // --------------------------------------------------------------------------
  // Sizing. The depth D must be a power of two: array indices are taken as
  // the low IW pointer bits and the top bit is the wrap flag, so the
  // modular subtraction tail - head gives the occupancy directly.
  // --------------------------------------------------------------------------
  localparam int D   = NUM_PR - NUM_ARCH;
  localparam int PRW = $clog2(NUM_PR);
  localparam int RW  = $clog2(NUM_ROB);
  localparam int IW  = $clog2(D);
  localparam int PW  = IW + 1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PRW-1:0] r_fl [D];
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [PW-1:0]  w_free_count;
  logic           w_fl_valid;
  logic [PW-1:0]  w_head_p1;
  logic [PW-1:0]  w_head_p2;
  logic [PW-1:0]  w_tail_p1;
  logic [PW-1:0]  w_ckpt_rd;
  logic [PW-1:0]  w_head_nxt;
  logic [PW-1:0]  w_tail_nxt;
  logic [1:0]     w_retire_cnt;
  logic           w_do_dispatch;
  logic           w_do_rollback;
  logic [PRW-1:0] w_told0;
  logic [PRW-1:0] w_told1;

  assign w_free_count = r_tail - r_head;
  assign w_fl_valid   = (w_free_count >= PW'(2));

  assign w_head_p1 = r_head + PW'(1);
  assign w_head_p2 = r_head + PW'(2);
  assign w_tail_p1 = r_tail + PW'(1);

  assign w_told0 = Told_idx[PRW-1:0];
  assign w_told1 = Told_idx[2*PRW-1:PRW];

  // Rollback takes priority over dispatch: the dispatch group in the same
  // cycle belongs to the squashed path, so neither the pop nor its
  // checkpoint writes may take effect. A pop without two free tags is
  // ignored outright. FL_valid looks only at registered state; a
  // same-cycle retirement cannot rescue a pop.
  assign w_do_rollback = en & rollback_en;
  assign w_do_dispatch = en & dispatch_en & w_fl_valid & ~rollback_en;

  // Retire slot 1 is only meaningful together with slot 0; the illegal
  // pattern 2'b10 pushes nothing.
  always_comb begin
    w_retire_cnt = 2'd0;
    if (en) begin
      case (retire_en)
        2'b01:   w_retire_cnt = 2'd1;
        2'b11:   w_retire_cnt = 2'd2;
        default: w_retire_cnt = 2'd0;
      endcase
    end
  end

  always_comb begin
    w_head_nxt = r_head;
    if (w_do_rollback) begin
      w_head_nxt = w_ckpt_rd;
    end else if (w_do_dispatch) begin
      w_head_nxt = w_head_p2;
    end
  end

  // Retirement is independent of head movement: a rollback and a retire
  // in the same cycle both take effect.
  assign w_tail_nxt = r_tail + PW'(w_retire_cnt);

  // --------------------------------------------------------------------------
  // Pointers and tag array
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head <= '0;
      r_tail <= PW'(D);
      for (int i = 0; i < D; i++) begin
        r_fl[i] <= PRW'(NUM_ARCH + i);
      end
    end else begin
      r_head <= w_head_nxt;
      r_tail <= w_tail_nxt;
      if (w_retire_cnt != 2'd0) begin
        r_fl[r_tail[IW-1:0]] <= w_told0;
      end
      if (w_retire_cnt == 2'd2) begin
        r_fl[w_tail_p1[IW-1:0]] <= w_told1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Checkpoint table. Slot 0 records head+1 (its own tag consumed), slot 1
  // records head+2 (both tags consumed), so restoring at a branch keeps the
  // branch's group up to and including the branch allocated.
  // --------------------------------------------------------------------------
  fl_checkpoint_table #(
    .DEPTH  (NUM_ROB),
    .IDX_W  (RW),
    .DATA_W (PW)
  ) u_ckpt (
    .clock   (clock),
    .reset   (reset),
    .wr_en   ({2{w_do_dispatch}}),
    .wr_idx  (ROB_idx),
    .wr_data ({w_head_p2, w_head_p1}),
    .rd_idx  (ROB_rollback_idx),
    .rd_data (w_ckpt_rd)
  );

  // --------------------------------------------------------------------------
  // Outputs. T_idx reflects the current head, so a tag pushed or a head
  // restored at edge N is offered from cycle N+1 on.
  // --------------------------------------------------------------------------
  assign T_idx      = {r_fl[w_head_p1[IW-1:0]], r_fl[r_head[IW-1:0]]};
  assign FL_valid   = w_fl_valid;
  assign free_count = w_free_count;

`ifdef FL_DEBUG_EN
  generate
    for (genvar g = 0; g < D; g++) begin : g_fl_debug
      assign fl_debug[g*PRW +: PRW] = r_fl[g];
    end
  endgenerate

  assign head_debug = r_head;
  assign tail_debug = r_tail;

  always @(posedge clock) begin
    if (reset && en) begin
      if (dispatch_en) begin
        assert (w_fl_valid);
      end
      assert (retire_en != 2'b10);
      assert ((int'(w_free_count) + int'(w_retire_cnt)) <= D);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// ============================================================================
// Module   : tb_free_list
// Purpose  : Self-checking bench for free_list. A queue-free reference model
//            tracks head/tail as unbounded counters over a tag ring and
//            checks T_idx, free_count and FL_valid every cycle; directed
//            scenarios add hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_free_list;

  localparam int D    = 32;
  localparam int NROB = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        en;
  logic        dispatch_en;
  logic [9:0]  ROB_idx;
  logic [1:0]  retire_en;
  logic [11:0] Told_idx;
  logic        rollback_en;
  logic [4:0]  ROB_rollback_idx;
  logic [11:0] T_idx;
  logic        FL_valid;
  logic [5:0]  free_count;

  free_list dut (
    .clock            (clock),
    .reset            (reset),
    .en               (en),
    .dispatch_en      (dispatch_en),
    .ROB_idx          (ROB_idx),
    .retire_en        (retire_en),
    .Told_idx         (Told_idx),
    .rollback_en      (rollback_en),
    .ROB_rollback_idx (ROB_rollback_idx),
    .T_idx            (T_idx),
    .FL_valid         (FL_valid),
    .free_count       (free_count)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  // Reference model: tag ring plus unbounded allocate/free counters
  int m_head;
  int m_tail;
  int m_fl   [D];
  int m_ckpt [NROB];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_fc();
    return ((m_tail - m_head) % 64 + 64) % 64;
  endfunction

  task automatic model_reset();
    m_head = 0;
    m_tail = D;
    for (int i = 0; i < D; i++) m_fl[i] = 32 + i;
    for (int i = 0; i < NROB; i++) m_ckpt[i] = 0;
  endtask

  task automatic model_step();
    int fc;
    int n;
    int nh;
    if (reset !== 1'b1 || en !== 1'b1) return;
    fc = exp_fc();
    n  = (retire_en == 2'b11) ? 2 : (retire_en == 2'b01) ? 1 : 0;
    nh = m_head;
    if (rollback_en) begin
      nh = m_ckpt[ROB_rollback_idx];
    end else if (dispatch_en && fc >= 2) begin
      m_ckpt[ROB_idx[4:0]] = m_head + 1;
      m_ckpt[ROB_idx[9:5]] = m_head + 2;
      nh = m_head + 2;
    end
    if (n >= 1) m_fl[m_tail % D] = Told_idx[5:0];
    if (n == 2) m_fl[(m_tail + 1) % D] = Told_idx[11:6];
    m_tail = m_tail + n;
    m_head = nh;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic drive(input logic d, input int r0, input int r1,
                       input logic [1:0] ret, input int t0, input int t1,
                       input logic rb, input int rbi);
    dispatch_en      = d;
    ROB_idx          = {5'(r1), 5'(r0)};
    retire_en        = ret;
    Told_idx         = {6'(t1), 6'(t0)};
    rollback_en      = rb;
    ROB_rollback_idx = 5'(rbi);
  endtask

  task automatic check_out(input string name, input int t0, input int t1,
                           input int fc, input int v);
    check({name, ".T0"},  int'(T_idx[5:0]),  t0);
    check({name, ".T1"},  int'(T_idx[11:6]), t1);
    check({name, ".cnt"}, int'(free_count),  fc);
    check({name, ".vld"}, int'(FL_valid),    v);
  endtask

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    if (chk_en) begin
      check("model.T0",  int'(T_idx[5:0]),  m_fl[m_head % D]);
      check("model.T1",  int'(T_idx[11:6]), m_fl[(m_head + 1) % D]);
      check("model.cnt", int'(free_count),  exp_fc());
      check("model.vld", int'(FL_valid),    int'(exp_fc() >= 2));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    en    = 1'b1;
    drive(1'b0, 0, 0, 2'b00, 0, 0, 1'b0, 0);
    model_reset();
    repeat (2) tick();
    chk_en = 1'b1;
    check_out("reset", 32, 33, 32, 1);

    reset = 1'b1;
    tick();
    check_out("idle", 32, 33, 32, 1);

    // 16 back-to-back dispatches hand out 32..63 in order
    for (int k = 0; k < 16; k++) begin
      check("disp.T0", int'(T_idx[5:0]),  32 + 2 * k);
      check("disp.T1", int'(T_idx[11:6]), 33 + 2 * k);
      drive(1'b1, (2 * k) % NROB, (2 * k + 1) % NROB, 2'b00, 0, 0, 1'b0, 0);
      tick();
    end
    check_out("empty", 32, 33, 0, 0);

    // 17th pop with nothing free: head must not move
    tick();
    check_out("pop_invalid", 32, 33, 0, 0);

    // Retire {5,7}, then {9,11}; freed tags are poppable next cycle
    drive(1'b0, 0, 0, 2'b11, 5, 7, 1'b0, 0);
    tick();
    check_out("retire1", 5, 7, 2, 1);
    drive(1'b0, 0, 0, 2'b11, 9, 11, 1'b0, 0);
    tick();
    check_out("retire2", 5, 7, 4, 1);
    drive(1'b1, 16, 17, 2'b00, 0, 0, 1'b0, 0);
    tick();
    check_out("pop_freed", 9, 11, 2, 1);

    // Illegal retire pattern pushes nothing; single retire pushes one
    drive(1'b0, 0, 0, 2'b10, 13, 12, 1'b0, 0);
    tick();
    check_out("retire_10", 9, 11, 2, 1);
    drive(1'b0, 0, 0, 2'b01, 20, 0, 1'b0, 0);
    tick();
    check_out("retire_01", 9, 11, 3, 1);

    // en low freezes all state
    en = 1'b0;
    drive(1'b1, 18, 19, 2'b11, 1, 2, 1'b0, 0);
    tick();
    check_out("en_low", 9, 11, 3, 1);
    en = 1'b1;
    drive(1'b0, 0, 0, 2'b00, 0, 0, 1'b0, 0);

    // Clean reset, then a dispatch stream cut by an async reset pulse
    reset = 1'b0;
    model_reset();
    tick();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2 * k, 2 * k + 1, 2'b00, 0, 0, 1'b0, 0);
      tick();
    end
    check_out("stream", 38, 39, 26, 1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_out("async_rst", 32, 33, 32, 1);
    drive(1'b0, 0, 0, 2'b00, 0, 0, 1'b0, 0);
    tick();
    reset = 1'b1;

    // Four groups into ROB 0..7, then roll back to ROB entry 3
    for (int g = 0; g < 4; g++) begin
      drive(1'b1, 2 * g, 2 * g + 1, 2'b00, 0, 0, 1'b0, 0);
      tick();
    end
    check_out("four_groups", 40, 41, 24, 1);
    drive(1'b0, 0, 0, 2'b00, 0, 0, 1'b1, 3);
    tick();
    check_out("rollback3", 36, 37, 28, 1);

    // One more group into ROB 8/9 (head 4 -> 6)
    drive(1'b1, 8, 9, 2'b00, 0, 0, 1'b0, 0);
    tick();
    check_out("group8", 38, 39, 26, 1);

    // Rollback + dispatch + dual retire in one cycle
    drive(1'b1, 10, 11, 2'b11, 2, 3, 1'b1, 8);
    tick();
    check_out("combined", 37, 38, 29, 1);

    // ROB 10 was never checkpointed (pop dropped), so it still holds 0
    drive(1'b0, 0, 0, 2'b00, 0, 0, 1'b1, 10);
    tick();
    check_out("no_ckpt", 2, 3, 34, 1);
    drive(1'b0, 0, 0, 2'b00, 0, 0, 1'b0, 0);
    tick();

    chk_en = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/free_list.md
# free_list

Physical-register free list for the 2-wide R10000-style core. It supplies two fresh physical tags (`T_idx`) per dispatch group to the ROB and Map Table. It reclaims the two `Told_idx` tags released at ROB retirement. On branch mispredict it restores its allocation pointer from a per-ROB-entry checkpoint, which returns the squashed tags to the free pool in one cycle.

## Interface
- `NUM_PR`, 64: physical registers; tag width `PRW = $clog2(NUM_PR)`.
- `NUM_ARCH`, 32: architectural registers; free-list depth `D = NUM_PR - NUM_ARCH`.
- `NUM_ROB`, 32: ROB entries; index width `RW = $clog2(NUM_ROB)`.
- `NUM_SUPER`, 2: dispatch and retire width.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `en` in 1: global state-update enable; when low all state holds.
- `dispatch_en` in 1: pop two tags this cycle.
- `ROB_idx` in 2×RW: ROB slots receiving the two dispatched ops.
- `retire_en` in 2: retire slot valid; `[1]` only with `[0]`.
- `Told_idx` in 2×PRW: tags freed by retiring ops.
- `rollback_en` in 1: mispredict recovery this cycle.
- `ROB_rollback_idx` in RW: ROB index of the mispredicted branch.
- `T_idx` out 2×PRW: tags allocated if `dispatch_en`.
- `FL_valid` out 1: at least two tags free.
- `free_count` out $clog2(D)+1: number of free tags.

## Operation
- State:
  - Tag array `fl[D]`.
  - `head` and `tail` pointers, each $clog2(D)+1 bits including a wrap bit.
  - Checkpoint table `ckpt[NUM_ROB]` of head-width values.
- `free_count = tail - head` (modulo 2^($clog2(D)+1)).
- `T_idx[0] = fl[head]`, `T_idx[1] = fl[head+1]`, with the index wrapping mod D. Both are combinational.
- `FL_valid = free_count >= 2`. Same-cycle retirements are not bypassed.
- Dispatch: `head += 2`; `ckpt[ROB_idx[0]] = head+1`; `ckpt[ROB_idx[1]] = head+2`.
- Retire:
  - `retire_en[0]` writes `fl[tail] = Told_idx[0]`.
  - Both slots retiring additionally writes `fl[tail+1] = Told_idx[1]`.
  - `tail` advances by the number of slots retired.
- Rollback: `head = ckpt[ROB_rollback_idx]`. This frees every tag allocated after the branch. Tags popped for the branch's own group up to and including the branch stay allocated.
- Simultaneous events:
  - Rollback and dispatch in the same cycle: rollback wins, the pop is dropped, and no checkpoint is written.
  - Rollback and retire in the same cycle: both apply (head restored, tail advanced).
  - Dispatch and retire in the same cycle: both apply.
- Protocol errors:
  - `dispatch_en` with `!FL_valid`: the pop is ignored.
  - `retire_en == 2'b10`: treated as no retire.
  - A push when `free_count == D` cannot occur by construction.

## Timing
- All pointer, array and checkpoint updates occur at the rising clock edge when `en` is high.
- Reset (async, active-low) sets:
  - `head = 0` and `tail = D` (wrap bit set).
  - `fl[i] = NUM_ARCH + i`.
  - `ckpt[*] = 0`.
- Outputs during and right after reset: `T_idx = {33,32}`, `free_count = 32`, `FL_valid = 1`.
- Reset asserted mid-operation discards all allocations and pending rollbacks immediately.
- Latency:
  - A tag freed at retire in cycle N can be allocated in cycle N+1.
  - After a rollback at cycle N, the restored tags are visible on `T_idx` in cycle N+1.
- Pointer wrap-around is handled by the wrap bit; `head == tail` means empty and never full.

## Configuration
- `FL_DEBUG_EN` defined:
  - Adds outputs `fl_debug` (D×PRW array), `head_debug` and `tail_debug`.
  - Enables immediate assertions for pop-when-invalid, push-when-full and `retire_en == 2'b10`.
- `FL_DEBUG_EN` undefined: these ports and assertions are absent and functional behaviour is identical.

## Structure
- Shared package `sys_defs` holds:
  - Constants `NUM_PR`, `NUM_ARCH`, `NUM_ROB`, `NUM_SUPER`.
  - Struct `FL_ROB_OUT_t` (`T_idx`).
  - Struct `ROB_FL_OUT_t` (`Told_idx`).
  - Typedef `PR_IDX_t`.
- One sub-module, `fl_checkpoint_table`:
  - Two write ports (dispatch) and one asynchronous read port (rollback).
  - Asynchronous active-low reset.
  - Instantiated once.

## Test plan
- Reset, then idle: `T_idx = {33,32}`, `free_count = 32`, `FL_valid = 1`.
- 16 back-to-back dispatches:
  - Tags 32..63 are handed out in order.
  - Afterwards `free_count = 0` and `FL_valid = 0`.
  - A 17th `dispatch_en` leaves `head` unchanged.
- Retire of `Told = {5,7}`, then dispatch: the next `T_idx = {5,7}` once the pointer wraps to them; `free_count` rises by 2 per retire cycle.
- Dispatch 4 groups into ROB slots 0..7, then rollback with `ROB_rollback_idx = 3`: `head = ckpt[3] = 4`, `free_count = 28`, next `T_idx = {36,37}`.
- Rollback, dispatch and dual retire in one cycle: head is restored, the pop is dropped, tail advances by 2, and `free_count = restored + 2`.
- Async reset pulse mid-dispatch stream: outputs return to reset values immediately, without waiting for a clock edge.
